// File: rtl/fifo_skew_scheduler.sv
// rtl/fifo_skew_scheduler.sv - clear/load/skewed-drain sequencer for a bank of systolic row FIFOs.
// Optional macro SCHED_STALL_EN adds a stall input that freezes the drain schedule.
module fifo_skew_scheduler #(
  parameter int ARRAY_SIZE = 9,
  parameter int DATA_SIZE  = 8,
  parameter int VEC_LEN    = 16,
  parameter int LOG_LEN    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_SIZE-1:0]  in_data,
  output logic                  in_ready,
  input  logic [ARRAY_SIZE-1:0] fifo_full,
  input  logic [ARRAY_SIZE-1:0] fifo_empty,
  output logic                  fifo_clear,
  output logic [ARRAY_SIZE-1:0] fifo_w_en,
  output logic [DATA_SIZE-1:0]  fifo_data_in,
  output logic [ARRAY_SIZE-1:0] fifo_r_en,
  output logic [ARRAY_SIZE-1:0] row_valid,
  output logic                  busy,
  output logic                  done,
`ifdef SCHED_STALL_EN
  input  logic                  stall,
`endif
  output logic                  err_underflow
);

  localparam int SEL_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam logic [SEL_W-1:0]   LAST_ROW  = SEL_W'(ARRAY_SIZE - 1);
  localparam logic [LOG_LEN-1:0] LAST_WORD = LOG_LEN'(VEC_LEN - 1);
  localparam logic [LOG_LEN-1:0] LAST_T    = LOG_LEN'(VEC_LEN + ARRAY_SIZE - 2);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      wsel_q, wsel_d;
  logic [LOG_LEN-1:0]    wcnt_q, wcnt_d;
  logic [LOG_LEN-1:0]    t_q, t_d;
  logic                  clear_q, clear_d;
  logic [ARRAY_SIZE-1:0] w_en_q, w_en_d;
  logic [DATA_SIZE-1:0]  data_q, data_d;
  logic [ARRAY_SIZE-1:0] r_en_q, r_en_d;
  logic [ARRAY_SIZE-1:0] valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  stall_w;
  logic                  accept;

`ifdef SCHED_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign in_ready = (state_q == S_LOAD) && !fifo_full[wsel_q];
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    wsel_d  = wsel_q;
    wcnt_d  = wcnt_q;
    t_d     = t_q;
    clear_d = 1'b0;
    w_en_d  = '0;
    data_d  = data_q;
    r_en_d  = '0;
    valid_d = r_en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          clear_d = 1'b1;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d = S_LOAD;
        wsel_d  = '0;
        wcnt_d  = '0;
      end
      S_LOAD: begin
        if (accept) begin
          w_en_d = ARRAY_SIZE'(1) << wsel_q;
          data_d = in_data;
          if (wcnt_q == LAST_WORD) begin
            wcnt_d = '0;
            if (wsel_q == LAST_ROW) begin
              wsel_d  = '0;
              t_d     = '0;
              state_d = S_DRAIN;
            end else begin
              wsel_d = wsel_q + SEL_W'(1);
            end
          end else begin
            wcnt_d = wcnt_q + LOG_LEN'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!stall_w) begin
          // Row i reads during t in [i, i+VEC_LEN): the one-cycle-per-row skew.
          for (int i = 0; i < ARRAY_SIZE; i++) begin
            if ((int'(t_q) >= i) && (int'(t_q) < i + VEC_LEN)) begin
              if (fifo_empty[i]) err_d = 1'b1;
              else               r_en_d[i] = 1'b1;
            end
          end
          if (t_q == LAST_T) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            t_d = t_q + LOG_LEN'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wsel_q  <= '0;
      wcnt_q  <= '0;
      t_q     <= '0;
      clear_q <= 1'b0;
      w_en_q  <= '0;
      data_q  <= '0;
      r_en_q  <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wsel_q  <= wsel_d;
      wcnt_q  <= wcnt_d;
      t_q     <= t_d;
      clear_q <= clear_d;
      w_en_q  <= w_en_d;
      data_q  <= data_d;
      r_en_q  <= r_en_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign fifo_clear    = clear_q;
  assign fifo_w_en     = w_en_q;
  assign fifo_data_in  = data_q;
  assign fifo_r_en     = r_en_q;
  assign row_valid     = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_underflow = err_q;

endmodule

// File: doc/fifo_skew_scheduler.md
Name: fifo_skew_scheduler

Overview:
- Sequences a bank of ARRAY_SIZE row FIFOs that feed the systolic array: clears them, loads a tile from one input stream in row-major order, then drains them with a one-cycle-per-row skew for systolic injection.
- Sits between the tile-load path and the per-row fifo instances.
- Drives their w_en, r_en, clear and shared dataIn; observes their full and empty flags.

Parameters:
- ARRAY_SIZE, 9: number of rows/FIFOs controlled.
- DATA_SIZE, 8: word width.
- VEC_LEN, 16: words per row per tile; must be 1..fifo_depth (256).
- LOG_LEN, 5: counter width; must satisfy 2^LOG_LEN > VEC_LEN+ARRAY_SIZE.

Ports:
- clk  in  1  single clock for the block and all controlled FIFOs (r_clk = w_clk = clk).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a tile.
- in_valid  in  1  input word valid.
- in_data  in  DATA_SIZE  input word.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- fifo_full  in  ARRAY_SIZE  per-row full flags.
- fifo_empty  in  ARRAY_SIZE  per-row empty flags.
- fifo_clear  out  1  clear to all FIFOs.
- fifo_w_en  out  ARRAY_SIZE  per-row write enable.
- fifo_data_in  out  DATA_SIZE  broadcast write data.
- fifo_r_en  out  ARRAY_SIZE  per-row read enable.
- row_valid  out  ARRAY_SIZE  FIFO dataOut of row i is valid this cycle.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of drain.
- err_underflow  out  1  sticky; a scheduled read hit an empty FIFO.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; all counters 0. Reset does not clear FIFO contents; the next start issues a clear.
- All outputs are registered except in_ready.
- IDLE:
  - On start: go to CLEAR; err_underflow <= 0.
  - start while busy is ignored.
- CLEAR: fifo_clear=1 for exactly one cycle, then go to LOAD with wsel=0 and wcnt=0.
- LOAD:
  - in_ready = (state==LOAD) && !fifo_full[wsel].
  - On accept: next cycle fifo_w_en[wsel]=1 (one-hot) and fifo_data_in=in_data.
  - wcnt increments; when wcnt reaches VEC_LEN-1 on an accept, wcnt <= 0 and wsel++.
  - The accept of word ARRAY_SIZE*VEC_LEN-1 moves to DRAIN. The last write lands in the cycle of DRAIN entry; first reads occur one cycle later.
  - in_valid low: no write, no count change.
- DRAIN:
  - Counter t runs 0..VEC_LEN+ARRAY_SIZE-2 (one tick per cycle).
  - Registered fifo_r_en[i] = 1 in the cycle after t satisfies i <= t < i+VEC_LEN.
  - If a scheduled read targets a row with fifo_empty[i]=1: that r_en bit is suppressed and err_underflow <= 1.
  - After the last t, go to DONE.
- row_valid[i] = fifo_r_en[i] delayed one cycle (FIFO read latency 1), including the final read of the last row.
- DONE: done=1 for one cycle, then IDLE. busy falls in the same cycle done is asserted.
- Total latency from start to done, with in_valid held high: 1 (CLEAR) + ARRAY_SIZE*VEC_LEN + (VEC_LEN+ARRAY_SIZE-1) + 1 cycles.
- start asserted in the DONE cycle is ignored.

Optional Feature:
- Macro: SCHED_STALL_EN.
- When defined, adds input port stall (1 bit). stall=1 in DRAIN freezes t and forces all fifo_r_en to 0 next cycle; row_valid follows one cycle later. No effect in other states.
- When undefined, the stall port is absent and drain runs uninterrupted.

Test Plan:
- ARRAY_SIZE=3, VEC_LEN=4; reset, start pulse → fifo_clear high exactly 1 cycle; busy=1; in_ready=1 the next cycle.
- Stream words 0x01..0x0C continuously → rows 0/1/2 receive 0x01-04 / 0x05-08 / 0x09-0C via one-hot fifo_w_en; in_ready drops after 12 accepts.
- Drain after full load → fifo_r_en row0 high drain cycles 1-4, row1 2-5, row2 3-6; row_valid one cycle later; done pulses once; err_underflow=0.
- Insert in_valid gaps (every other cycle) → same data and row mapping; load stretches to 24 cycles.
- Force fifo_empty[1]=1 during drain → row1 r_en stays 0; err_underflow=1 and stays set until the next start.
- rst_n low mid-LOAD, then start again → all outputs 0 during reset; new start re-clears; full tile completes correctly.
